// File: rtl/score_digit_encoder_if.sv
// Bundle of the score encoder's control inputs and display/count outputs.
interface score_digit_encoder_if #(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned DIGITS = 4
);
  logic                  clear;
  logic                  coin_evt;
  logic                  pipe_evt;
  logic                  sel;
  logic [CNT_W-1:0]      num_coins;
  logic [CNT_W-1:0]      num_pipes;
  logic [4*DIGITS-1:0]   hex_digits;
  logic                  valid;
  logic                  busy;
  logic                  overflow;

  modport master (
    output clear, coin_evt, pipe_evt, sel,
    input  num_coins, num_pipes, hex_digits, valid, busy, overflow
  );

  modport slave (
    input  clear, coin_evt, pipe_evt, sel,
    output num_coins, num_pipes, hex_digits, valid, busy, overflow
  );
endinterface

// File: rtl/score_digit_encoder.sv
// Saturating coin/pipe event counters with a serial double-dabble converter
// driving a registered BCD digit word for the hex displays.
module score_digit_encoder #(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned DIGITS = 4
) (
  input logic                 Clk,
  input logic                 Reset,
  score_digit_encoder_if.slave bus
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned ITER_W = $clog2(CNT_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  coins;
  logic [CNT_W-1:0]  pipes;
  logic [BCD_W-1:0]  digits;
  logic              valid;
  logic              busy;
  logic              overflow;
  logic              prev_coin;
  logic              prev_pipe;
  logic              dirty;
  logic              sel_q;
  logic [CNT_W-1:0]  bin;
  logic [BCD_W-1:0]  bcd;
  logic [ITER_W-1:0] iter;

  logic              coin_hit_c;
  logic              pipe_hit_c;
  logic              coin_max_c;
  logic              pipe_max_c;
  logic              dirty_set_c;
  logic [BCD_W-1:0]  adj_c;
  logic [BCD_W-1:0]  shift_bcd_c;
  logic [CNT_W-1:0]  shift_bin_c;

  assign bus.num_coins  = coins;
  assign bus.num_pipes  = pipes;
  assign bus.hex_digits = digits;
  assign bus.valid      = valid;
  assign bus.busy       = busy;
  assign bus.overflow   = overflow;

  // Rising-edge events; a saturated counter does not count as a change.
  assign coin_hit_c  = bus.coin_evt & ~prev_coin;
  assign pipe_hit_c  = bus.pipe_evt & ~prev_pipe;
  assign coin_max_c  = (coins == {CNT_W{1'b1}});
  assign pipe_max_c  = (pipes == {CNT_W{1'b1}});
  assign dirty_set_c = bus.clear
                     | (coin_hit_c & ~coin_max_c)
                     | (pipe_hit_c & ~pipe_max_c)
                     | (bus.sel != sel_q);

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    adj_c = bcd;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        adj_c[4*d +: 4] = 4'(bcd[4*d +: 4] + 4'd3);
      end
    end
    shift_bcd_c = {adj_c[BCD_W-2:0], bin[CNT_W-1]};
    shift_bin_c = {bin[CNT_W-2:0], 1'b0};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      coins     <= '0;
      pipes     <= '0;
      digits    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      prev_coin <= 1'b0;
      prev_pipe <= 1'b0;
      dirty     <= 1'b0;
      sel_q     <= 1'b0;
      bin       <= '0;
      bcd       <= '0;
      iter      <= '0;
    end else begin
      prev_coin <= bus.coin_evt;
      prev_pipe <= bus.pipe_evt;
      valid     <= 1'b0;

      // clear wins over same-cycle events
      if (bus.clear) begin
        coins    <= '0;
        pipes    <= '0;
        overflow <= 1'b0;
      end else begin
        if (coin_hit_c) begin
          if (coin_max_c) overflow <= 1'b1;
          else            coins    <= coins + CNT_W'(1);
        end
        if (pipe_hit_c) begin
          if (pipe_max_c) overflow <= 1'b1;
          else            pipes    <= pipes + CNT_W'(1);
        end
      end

      if (dirty_set_c)                  dirty <= 1'b1;
      else if (state == IDLE && dirty)  dirty <= 1'b0;

      // Outputs are registered on entry to the state they belong to.
      case (state)
        IDLE: begin
          if (dirty) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          bin   <= bus.sel ? pipes : coins;
          sel_q <= bus.sel;
          bcd   <= '0;
          iter  <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd  <= shift_bcd_c;
          bin  <= shift_bin_c;
          iter <= iter + ITER_W'(1);
          if (iter == ITER_W'(CNT_W - 1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            digits <= shift_bcd_c;
            valid  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/score_digit_encoder.md
Name: score_digit_encoder

Overview:
- Produces the packed BCD digit nibbles that feed the four HexDriver instances, in place of per-event flag edges used as clocks.
- Counts coin-collection and pipe-passed events synchronously on one clock, with saturating counters.
- Converts the selected score to BCD with a serial double-dabble engine.
- Presents the result as a glitch-free registered 16-bit digit word, plus a one-cycle valid pulse per update.

Parameters:
- CNT_W, 10: width of each score counter; also the number of SHIFT iterations.
- DIGITS, 4: number of BCD output digits. Must satisfy 10^DIGITS > 2^CNT_W - 1.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous zeroing of both counters and the overflow flag.
- coin_evt  input  1  coin-collected level, synchronous to Clk; counted on its rising edge.
- pipe_evt  input  1  pipe-passed level, synchronous to Clk; counted on its rising edge.
- sel  input  1  display select: 0 = coins, 1 = pipes.
- num_coins  output  CNT_W  coin count.
- num_pipes  output  CNT_W  pipe count.
- hex_digits  output  4*DIGITS  BCD digits; bits [3:0] are the least significant digit.
- valid  output  1  one-cycle pulse when hex_digits updates.
- busy  output  1  high while a conversion is in progress.
- overflow  output  1  sticky; set when any counter saturates.

Behaviour:
- Reset (asynchronous, any state): num_coins, num_pipes, hex_digits, valid, busy, overflow, the edge-detect registers and the dirty flag all go to 0; FSM goes to IDLE.
- Edge detect: prev_x <= x every cycle. An event is x & ~prev_x. A level held high counts once.
- Counters:
  - On an event, the counter increments by 1.
  - At 2^CNT_W - 1 (1023 by default) the counter holds and overflow is set to 1.
  - Coin and pipe events in the same cycle are both counted.
  - clear has priority over events in the same cycle; those events are dropped.
  - clear zeroes both counters, clears overflow and sets dirty.
- dirty flag:
  - Set on any counter change, on clear, or when sel differs from the registered sel_q.
  - Cleared when the FSM leaves IDLE.
  - If a set condition and the clear condition occur in the same cycle, set wins.
- FSM states IDLE, LOAD, SHIFT, DONE:
  - IDLE: if dirty, go to LOAD; busy = 0.
  - LOAD (1 cycle): snapshot bin <= (sel ? num_pipes : num_coins); sel_q <= sel; bcd <= 0; iter <= 0; busy = 1.
  - SHIFT (CNT_W cycles): each cycle, every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1; iter++. After iteration CNT_W-1 go to DONE.
  - DONE (1 cycle): hex_digits <= bcd; valid = 1 for this cycle only; go to IDLE.
- Latency: dirty to hex_digits update = CNT_W + 2 cycles (12 by default). Back-to-back conversions are separated by one IDLE cycle.
- hex_digits holds its previous value throughout LOAD and SHIFT (no intermediate values visible).
- Events or a sel change during a conversion:
  - The counters update immediately.
  - dirty is set, so a reconversion starts right after DONE, via IDLE.
  - The in-flight conversion completes using its snapshot.
- Reset during SHIFT aborts the conversion and hex_digits reads 0. Any pending event is discarded.
- BCD nibbles never exceed 9.

Test Plan:
1. Reset asserted for 2 cycles -> all outputs 0, FSM in IDLE, no valid pulse.
2. One coin_evt rising edge, sel=0 -> num_coins=1; 12 cycles later hex_digits=16'h0001 with a single-cycle valid; busy high for exactly 11 cycles.
3. 1023 pipe pulses, sel=1 -> hex_digits=16'h1023, overflow=0. A 1024th pulse -> num_pipes stays 1023, overflow=1. Then clear -> counters 0, overflow 0, hex_digits=16'h0000 after reconversion.
4. coin_evt and pipe_evt rising in the same cycle -> both counters +1. A clear in the same cycle as an event -> counters 0, the event is not counted.
5. 3 coin events while busy, starting from 7 -> first DONE shows 16'h0007, the immediate reconversion shows 16'h0010. Toggling sel with coins=5, pipes=42 -> 16'h0042.
6. Reset pulse mid-SHIFT -> hex_digits=0, busy=0, no valid. Normal conversion resumes after the next event.
